// File: rtl/fsmplusd_pkg.sv
// Shared types for the FSM+D controller: state encoding, datapath select codes,
// the registered control bundle, and the next-state/output decode helpers.
package fsmplusd_pkg;

    typedef enum logic [2:0] {
        IDLE, LOAD, ACCUM, SWAP_D, MUL, LOAD_E, SUM, DONE
    } state_t;

    localparam logic [1:0] SEL1_MUL  = 2'd0;
    localparam logic [1:0] SEL1_ADD3 = 2'd1;
    localparam logic [1:0] SEL1_ADD2 = 2'd2;
    localparam logic [1:0] SEL1_A    = 2'd3;
    localparam logic [1:0] SEL2_MUL  = 2'd0;
    localparam logic [1:0] SEL2_ADD3 = 2'd1;
    localparam logic [1:0] SEL2_C    = 2'd2;
    localparam logic [1:0] SEL3_E    = 2'd0;
    localparam logic [1:0] SEL3_D    = 2'd1;
    localparam logic [1:0] SEL3_B    = 2'd2;

    typedef struct packed {
        logic [1:0] sel1;
        logic [1:0] sel2;
        logic [1:0] sel3;
        logic       ldr1;
        logic       ldr2;
        logic       ldr3;
        logic       busy;
        logic       done;
    } ctl_t;

    // abort only matters once a run is in flight; IDLE and DONE ignore it.
    function automatic state_t next_state(state_t s, logic start, logic abort,
                                          logic cnt_zero, logic cnt_one);
        next_state = s;
        if (abort && s != IDLE && s != DONE) begin
            next_state = IDLE;
        end else begin
            case (s)
                IDLE:    if (start) next_state = LOAD;
                LOAD:    next_state = cnt_zero ? SWAP_D : ACCUM;
                ACCUM:   if (cnt_one) next_state = SWAP_D;
                SWAP_D:  next_state = MUL;
                MUL:     next_state = LOAD_E;
                LOAD_E:  next_state = SUM;
                SUM:     next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    endfunction

    function automatic ctl_t decode(state_t s);
        decode = '0;
        case (s)
            LOAD: begin
                decode.sel1 = SEL1_A;
                decode.sel2 = SEL2_C;
                decode.sel3 = SEL3_B;
                decode.ldr1 = 1'b1;
                decode.ldr2 = 1'b1;
                decode.ldr3 = 1'b1;
                decode.busy = 1'b1;
            end
            ACCUM: begin
                decode.sel1 = SEL1_ADD3;
                decode.sel2 = SEL2_ADD3;
                decode.ldr1 = 1'b1;
                decode.ldr2 = 1'b1;
                decode.busy = 1'b1;
            end
            SWAP_D: begin
                decode.sel3 = SEL3_D;
                decode.ldr3 = 1'b1;
                decode.busy = 1'b1;
            end
            MUL: begin
                decode.sel1 = SEL1_MUL;
                decode.sel2 = SEL2_MUL;
                decode.ldr1 = 1'b1;
                decode.ldr2 = 1'b1;
                decode.busy = 1'b1;
            end
            LOAD_E: begin
                decode.sel3 = SEL3_E;
                decode.ldr3 = 1'b1;
                decode.busy = 1'b1;
            end
            SUM: begin
                decode.sel1 = SEL1_ADD2;
                decode.ldr1 = 1'b1;
                decode.busy = 1'b1;
            end
            DONE:    decode.done = 1'b1;
            default: decode = '0;
        endcase
    endfunction

endpackage

// File: rtl/fsmplusd_iter_cnt.sv
// Loadable down-counter holding the remaining accumulate iterations.
module fsmplusd_iter_cnt #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] din,
    output logic         zero,
    output logic         one
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= din;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
    assign one  = (count == W'(1));

endmodule

// File: rtl/fsmplusd_control_unit.sv
// FSM+D controller: sequences the R1/R2/R3 datapath through load, N accumulates,
// multiply and sum. Define FSMPLUSD_ABORT_EN to let abort cancel a run in flight.
module fsmplusd_control_unit
    import fsmplusd_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] iter,
    input  logic             abort,
    output logic [1:0]       sel1,
    output logic [1:0]       sel2,
    output logic [1:0]       sel3,
    output logic             ldR1,
    output logic             ldR2,
    output logic             ldR3,
    output logic             busy,
    output logic             done
);

    state_t state;
    ctl_t   ctl;
    logic   cnt_zero;
    logic   cnt_one;
    logic   abort_req;

`ifdef FSMPLUSD_ABORT_EN
    assign abort_req = abort;
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_req    = 1'b0;
`endif

    fsmplusd_iter_cnt #(.W(CNT_W)) u_iter_cnt (
        .clock (clock),
        .reset (reset),
        .load  (state == IDLE && start),
        .dec   (state == ACCUM),
        .din   (iter),
        .zero  (cnt_zero),
        .one   (cnt_one)
    );

    // Controls are registered from the next state so they line up with the state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ctl   <= '0;
        end else begin
            state <= next_state(state, start, abort_req, cnt_zero, cnt_one);
            ctl   <= decode(next_state(state, start, abort_req, cnt_zero, cnt_one));
        end
    end

    assign sel1 = ctl.sel1;
    assign sel2 = ctl.sel2;
    assign sel3 = ctl.sel3;
    assign ldR1 = ctl.ldr1;
    assign ldR2 = ctl.ldr2;
    assign ldR3 = ctl.ldr3;
    assign busy = ctl.busy;
    assign done = ctl.done;

endmodule

// File: tb/tb_fsmplusd_control_unit.sv
// Directed bench for fsmplusd_control_unit with a behavioural FSM+D datapath attached.
module tb_fsmplusd_control_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] iter  = 4'd0;
    logic       abort = 1'b0;
    logic [1:0] sel1, sel2, sel3;
    logic       ldR1, ldR2, ldR3, busy, done;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [11:0] exp_q[$];

    localparam logic [3:0] DP_A = 4'd1, DP_B = 4'd2, DP_C = 4'd3, DP_D = 4'd2, DP_E = 4'd1;

    // {sel1, sel2, sel3, ldR1, ldR2, ldR3, busy, done}
    localparam logic [10:0] V_IDLE = 11'b00_00_00_000_0_0;
    localparam logic [10:0] V_LOAD = 11'b11_10_10_111_1_0;
    localparam logic [10:0] V_ACC  = 11'b01_01_00_110_1_0;
    localparam logic [10:0] V_SWD  = 11'b00_00_01_001_1_0;
    localparam logic [10:0] V_MUL  = 11'b00_00_00_110_1_0;
    localparam logic [10:0] V_LDE  = 11'b00_00_00_001_1_0;
    localparam logic [10:0] V_SUM  = 11'b10_00_00_100_1_0;
    localparam logic [10:0] V_DONE = 11'b00_00_00_000_0_1;

    logic [10:0] outv;
    assign outv = {sel1, sel2, sel3, ldR1, ldR2, ldR3, busy, done};

    fsmplusd_control_unit #(.CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .iter  (iter),
        .abort (abort),
        .sel1  (sel1),
        .sel2  (sel2),
        .sel3  (sel3),
        .ldR1  (ldR1),
        .ldR2  (ldR2),
        .ldR3  (ldR3),
        .busy  (busy),
        .done  (done)
    );

    // clock / reset
    always #5 clock = ~clock;

    // attached datapath, 4-bit registers so arithmetic wraps mod 16
    logic [3:0] r1 = '0, r2 = '0, r3 = '0;
    always @(posedge clock) begin
        if (ldR1) begin
            case (sel1)
                2'd0: r1 <= r1 * r3;
                2'd1: r1 <= r1 + r3;
                2'd2: r1 <= r1 + r2;
                default: r1 <= DP_A;
            endcase
        end
        if (ldR2) begin
            case (sel2)
                2'd0: r2 <= r1 * r2;
                2'd1: r2 <= r2 + r3;
                2'd2: r2 <= DP_C;
                default: r2 <= 'x;
            endcase
        end
        if (ldR3) begin
            case (sel3)
                2'd0: r3 <= DP_E;
                2'd1: r3 <= DP_D;
                2'd2: r3 <= DP_B;
                default: r3 <= 'x;
            endcase
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one complete run; poke fires start while busy and while in DONE
    task automatic run(input int n, input logic [11:0] exp_regs, input bit poke);
        int d0;
        logic [11:0] e;
        d0 = done_cnt;
        exp_q.push_back(exp_regs);
        start = 1'b1;
        iter  = 4'(n);
        tick();
        start = 1'b0;
        iter  = 4'($urandom_range(0, 15));
        check($sformatf("n%0d_load", n), outv, V_LOAD);
        for (int i = 0; i < n; i++) begin
            if (poke && i == 0) start = 1'b1;
            tick();
            start = 1'b0;
            check($sformatf("n%0d_accum%0d", n, i), outv, V_ACC);
        end
        tick(); check($sformatf("n%0d_swap_d", n), outv, V_SWD);
        tick(); check($sformatf("n%0d_mul", n), outv, V_MUL);
        tick(); check($sformatf("n%0d_load_e", n), outv, V_LDE);
        tick(); check($sformatf("n%0d_sum", n), outv, V_SUM);
        tick(); check($sformatf("n%0d_done", n), outv, V_DONE);
        if (poke) start = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("n%0d_idle", n), outv, V_IDLE);
        tick(); check($sformatf("n%0d_idle2", n), outv, V_IDLE);
        e = exp_q.pop_front();
        check($sformatf("n%0d_regs", n), {r1, r2, r3}, e);
        check($sformatf("n%0d_done_cnt", n), done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        @(negedge clock);
        check("reset_outputs", outv, V_IDLE);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("idle%0d", i), outv, V_IDLE);
        end

        run(2,  {4'hD, 4'h3, 4'h1}, 1'b0);
        run(0,  {4'h5, 4'h3, 4'h1}, 1'b0);
        run(15, {4'hD, 4'hF, 4'h1}, 1'b0);
        run(1,  {4'h5, 4'hF, 4'h1}, 1'b0);
        run(2,  {4'hD, 4'h3, 4'h1}, 1'b1);

        // asynchronous reset while in MUL
        d0 = done_cnt;
        start = 1'b1; iter = 4'd1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        check("rst_pre_mul", outv, V_MUL);
        #2 reset = 1'b1;
        #1 check("rst_async", outv, V_IDLE);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("rst_after", outv, V_IDLE);
        check("rst_no_done", done_cnt - d0, 0);

        // abort raised in SWAP_D
        d0 = done_cnt;
        start = 1'b1; iter = 4'd1;
        tick(); start = 1'b0;
        tick(); tick();
        check("abort_swap_d", outv, V_SWD);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`ifdef FSMPLUSD_ABORT_EN
        check("abort_idle", outv, V_IDLE);
        for (int i = 0; i < 6; i++) tick();
        check("abort_stay_idle", outv, V_IDLE);
        check("abort_no_done", done_cnt - d0, 0);
`else
        check("abort_ignored_mul", outv, V_MUL);
        tick(); tick(); tick();
        check("abort_ignored_done", outv, V_DONE);
        tick();
        check("abort_ignored_idle", outv, V_IDLE);
        check("abort_ignored_done_cnt", done_cnt - d0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
